// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up in a final cycle before HI/LO update.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             mult_done,
  output logic             div_done,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    step_cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic             op_div;
  logic             neg_lo;
  logic             neg_hi;
  logic             zero_pend;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_accept;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  always_comb begin
    a_neg      = is_signed & a_in[WIDTH-1];
    b_neg      = is_signed & b_in[WIDTH-1];
    a_mag      = a_neg ? (~a_in + 1'b1) : a_in;
    b_mag      = b_neg ? (~b_in + 1'b1) : b_in;
    mult_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, mcand} : '0);
    div_shift  = {work_hi, work_lo[WIDTH-1]};
    div_accept = (div_shift >= {1'b0, mcand});
    // Partial remainder stays below the divisor, so the difference fits WIDTH bits
    div_diff   = div_shift[WIDTH-1:0] - mcand;
    prod_fix   = neg_lo ? (~{work_hi, work_lo} + 1'b1) : {work_hi, work_lo};
    q_fix      = neg_lo ? (~work_lo + 1'b1) : work_lo;
    r_fix      = neg_hi ? (~work_hi + 1'b1) : work_hi;
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state     <= IDLE;
      step_cnt  <= '0;
      mcand     <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      op_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      zero_pend <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
      busy      <= 1'b0;
      mult_done <= 1'b0;
      div_done  <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      mult_done <= 1'b0;
      div_done  <= zero_pend;
      div_zero  <= zero_pend;
      zero_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult || (start_div && (b_in != '0))) begin
            work_hi  <= '0;
            work_lo  <= a_mag;
            mcand    <= b_mag;
            op_div   <= ~start_mult;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= a_neg;
            step_cnt <= '0;
            busy     <= 1'b1;
            state    <= start_mult ? MULT : DIV;
          end else if (start_div) begin
            zero_pend <= 1'b1;
          end
        end
        MULT: begin
          work_hi  <= mult_sum[WIDTH:1];
          work_lo  <= {mult_sum[0], work_lo[WIDTH-1:1]};
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == CW'(WIDTH - 1)) begin
            step_cnt <= '0;
            state    <= FIX;
          end
        end
        DIV: begin
          work_hi  <= div_accept ? div_diff : div_shift[WIDTH-1:0];
          work_lo  <= {work_lo[WIDTH-2:0], div_accept};
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == CW'(WIDTH - 1)) begin
            step_cnt <= '0;
            state    <= FIX;
          end
        end
        FIX: begin
          if (op_div) begin
            hi_out   <= r_fix;
            lo_out   <= q_fix;
            div_done <= 1'b1;
          end else begin
            {hi_out, lo_out} <= prod_fix;
            mult_done        <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: 32-bit and 8-bit instances driven in
// lockstep, checked against an arithmetic reference model and fixed vectors.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        start_mult, start_div, is_signed, st_mult8, st_div8;
  logic [31:0] a_in, b_in;
  logic [31:0] hi32, lo32;
  logic        busy32, md32, dd32, dz32;
  logic [7:0]  hi8, lo8;
  logic        busy8, md8, dd8, dz8;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset_in(reset_in), .start_mult(start_mult), .start_div(start_div),
    .is_signed(is_signed), .a_in(a_in), .b_in(b_in), .hi_out(hi32), .lo_out(lo32),
    .busy(busy32), .mult_done(md32), .div_done(dd32), .div_zero(dz32)
  );

  mult_div_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset_in(reset_in), .start_mult(st_mult8), .start_div(st_div8),
    .is_signed(is_signed), .a_in(a_in[7:0]), .b_in(b_in[7:0]), .hi_out(hi8), .lo_out(lo8),
    .busy(busy8), .mult_done(md8), .div_done(dd8), .div_zero(dz8)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi32, m_lo32, m_hi8, m_lo8;
  logic [31:0] r_hi32, r_lo32;
  logic [7:0]  r_hi8, r_lo8;
  logic [2:0]  r_fl32, r_fl8;
  int          lat32, lat8, busy_cnt;
  bit          hold_bad;

  typedef struct {
    bit          m, d, s;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t tab[7];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Result of a w-bit operation by plain integer arithmetic; divide-by-zero holds.
  function automatic void model(input int w, input bit m, input bit d, input bit s,
                                input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    logic [63:0] mk, p;
    longint sa, sb;
    mk = (64'd1 << w) - 64'd1;
    sa = longint'(64'(a) & mk);
    sb = longint'(64'(b) & mk);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    if (m) begin
      p  = 64'(sa * sb);
      hi = 32'((p >> w) & mk);
      lo = 32'(p & mk);
    end else if (d && sb != 0) begin
      hi = 32'(64'(sa % sb) & mk);
      lo = 32'(64'(sa / sb) & mk);
    end
  endfunction

  // Called at a falling edge; returns at the falling edge where the 32-bit done shows.
  task automatic run_op(input bit m, input bit d, input bit s,
                        input logic [31:0] a, input logic [31:0] b, input int inject);
    int n;
    bit done32, seen8;
    start_mult = m; start_div = d; st_mult8 = m; st_div8 = d;
    is_signed = s; a_in = a; b_in = b;
    busy_cnt = 0; hold_bad = 0; n = 0; done32 = 0; seen8 = 0; lat8 = -1;
    r_fl8 = '0; r_hi8 = '0; r_lo8 = '0;
    @(negedge clk);
    start_mult = 0; start_div = 0; st_mult8 = 0; st_div8 = 0;
    chk("pulse_len", {58'd0, md32, dd32, dz32, md8, dd8, dz8}, 64'd0);
    while (!done32 && n < 100) begin
      if (!seen8 && (md8 || dd8)) begin
        seen8 = 1; lat8 = n; r_hi8 = hi8; r_lo8 = lo8; r_fl8 = {md8, dd8, dz8};
      end else if (!seen8 && (hi8 !== m_hi8[7:0] || lo8 !== m_lo8[7:0])) begin
        hold_bad = 1;
      end
      if (md32 || dd32) begin
        done32 = 1; r_hi32 = hi32; r_lo32 = lo32; r_fl32 = {md32, dd32, dz32};
      end else begin
        busy_cnt += int'(busy32);
        if (hi32 !== m_hi32 || lo32 !== m_lo32) hold_bad = 1;
        if (n == inject) begin
          start_div = 1; b_in = 32'd5;
        end else begin
          start_div = 0;
        end
        @(negedge clk);
        n++;
      end
    end
    start_div = 0;
    lat32 = n;
    chk("done_timeout", 64'(done32), 64'd1);
  endtask

  task automatic verify(input string tag, input bit m, input bit d, input bit s,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit use_tab, input logic [31:0] eh, input logic [31:0] el);
    bit zero32, zero8;
    logic [31:0] xh, xl;
    zero32 = !m && (b == 32'd0);
    zero8  = !m && (b[7:0] == 8'd0);
    xh = m_hi32; xl = m_lo32;
    model(32, m, d, s, a, b, xh, xl);
    if (!use_tab) begin eh = xh; el = xl; end
    chk({tag, "_hi"}, 64'(r_hi32), 64'(eh));
    chk({tag, "_lo"}, 64'(r_lo32), 64'(el));
    chk({tag, "_lat"}, 64'(lat32), zero32 ? 64'd1 : 64'd33);
    chk({tag, "_busy"}, 64'(busy_cnt), zero32 ? 64'd0 : 64'd33);
    chk({tag, "_flags"}, 64'(r_fl32), m ? 64'd4 : (zero32 ? 64'd3 : 64'd2));
    chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
    m_hi32 = xh; m_lo32 = xl;
    model(8, m, d, s, a, b, m_hi8, m_lo8);
    chk({tag, "_w8_hi"}, 64'(r_hi8), 64'(m_hi8[7:0]));
    chk({tag, "_w8_lo"}, 64'(r_lo8), 64'(m_lo8[7:0]));
    chk({tag, "_w8_lat"}, 64'(lat8), zero8 ? 64'd1 : 64'd9);
    chk({tag, "_w8_flags"}, 64'(r_fl8), m ? 64'd4 : (zero8 ? 64'd3 : 64'd2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m, d, s;
    logic [31:0] a, b;
    int cnt;

    tab[0] = '{1, 0, 0, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    tab[1] = '{1, 0, 1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tab[2] = '{0, 1, 0, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tab[3] = '{0, 1, 1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tab[4] = '{0, 1, 0, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};
    tab[5] = '{0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tab[6] = '{1, 1, 0, 32'h00000007, 32'h00000003, 32'h00000000, 32'h00000015};

    reset_in = 0; start_mult = 0; start_div = 0; st_mult8 = 0; st_div8 = 0;
    is_signed = 0; a_in = '0; b_in = '0;
    m_hi32 = '0; m_lo32 = '0; m_hi8 = '0; m_lo8 = '0;
    #12;
    chk("rst_hi", 64'(hi32), 64'd0);
    chk("rst_lo", 64'(lo32), 64'd0);
    chk("rst_ctl", {58'd0, busy32, md32, dd32, dz32, busy8, md8}, 64'd0);
    @(negedge clk);
    reset_in = 1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(tab[i].m, tab[i].d, tab[i].s, tab[i].a, tab[i].b, -1);
      verify($sformatf("vec%0d", i), tab[i].m, tab[i].d, tab[i].s, tab[i].a, tab[i].b,
             1, tab[i].hi, tab[i].lo);
    end

    // start_div during cycle 10 of a multiply must be ignored
    run_op(1, 0, 0, 32'd3, 32'd4, 10);
    verify("inject", 1, 0, 0, 32'd3, 32'd4, 1, 32'd0, 32'd12);

    run_op(1, 0, 1, 32'h00000080, 32'h000000FF, -1);
    verify("w8mul", 1, 0, 1, 32'h00000080, 32'h000000FF, 0, '0, '0);
    chk("w8_neg128_x_neg1_hi", 64'(r_hi8), 64'h00);
    chk("w8_neg128_x_neg1_lo", 64'(r_lo8), 64'h80);
    run_op(0, 1, 0, 32'd200, 32'd7, -1);
    verify("w8div", 0, 1, 0, 32'd200, 32'd7, 0, '0, '0);
    chk("w8_200_div_7_lo", 64'(r_lo8), 64'd28);
    chk("w8_200_div_7_hi", 64'(r_hi8), 64'd4);

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      d = !m || ($urandom_range(0, 3) == 0);
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 32'h80000000;
        1:       a = 32'h00000000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'h00000000;
        1:       b = 32'h00000001;
        2:       b = 32'hFFFFFFFF;
        3:       b = 32'h80000000;
        4:       b = $urandom & 32'hFFFFFF00;
        default: b = $urandom;
      endcase
      run_op(m, d, s, a, b, -1);
      verify($sformatf("rnd%0d", i), m, d, s, a, b, 0, '0, '0);
    end

    // Reset asserted mid-divide, between clock edges
    start_div = 1; st_div8 = 1; is_signed = 0; a_in = 32'd100; b_in = 32'd7;
    @(negedge clk);
    start_div = 0; st_div8 = 0;
    repeat (14) @(negedge clk);
    #1 reset_in = 0;
    #1;
    chk("midrst_hi", 64'(hi32), 64'd0);
    chk("midrst_lo", 64'(lo32), 64'd0);
    chk("midrst_ctl", {58'd0, busy32, md32, dd32, dz32, busy8, md8}, 64'd0);
    chk("midrst_w8", {48'd0, hi8, lo8}, 64'd0);
    m_hi32 = '0; m_lo32 = '0; m_hi8 = '0; m_lo8 = '0;
    @(negedge clk);
    reset_in = 1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt += int'(md32 | dd32 | dz32 | busy32);
    end
    chk("no_done_after_reset", 64'(cnt), 64'd0);
    run_op(1, 0, 0, 32'd6, 32'd7, -1);
    verify("post_rst", 1, 0, 0, 32'd6, 32'd7, 1, 32'd0, 32'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
